// File: rtl/ram_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one synchronous dual-port RAM between requesters A and B.
// Optional build macro ARB_FIXED_PRIO_EN: A always wins ties, no burst limit (B may starve).
module ram_port_arbiter #(
  parameter int unsigned MEM_WIDTH = 16,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [MEM_WIDTH-1:0] a_wdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [MEM_WIDTH-1:0] b_wdata,
  output logic                 a_gnt,
  output logic                 b_gnt,
  output logic                 a_rvalid,
  output logic                 b_rvalid,
  output logic [MEM_WIDTH-1:0] rdata,
  output logic [MEM_WIDTH-1:0] mem_din,
  output logic [ADDR_SIZE-1:0] mem_addr_wr,
  output logic [ADDR_SIZE-1:0] mem_addr_rd,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic                 mem_blk_select,
  input  logic [MEM_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t r_state;

`ifndef ARB_FIXED_PRIO_EN
  localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic             SIDE_A    = 1'b0;
  localparam logic             SIDE_B    = 1'b1;

  logic             r_rr_last;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             w_burst_ok;
`endif

  logic                 r_rd_pend_a;
  logic                 r_rd_pend_b;
  logic                 r_rvalid_a;
  logic                 r_rvalid_b;
  logic                 w_gnt_a;
  logic                 w_gnt_b;
  logic                 w_any_gnt;
  logic                 w_we;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [MEM_WIDTH-1:0] w_wdata;

  // Grant decision for the current cycle; never grants a side that is not requesting.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    if (a_req) begin
      w_gnt_a = 1'b1;
    end else if (b_req) begin
      w_gnt_b = 1'b1;
    end
`else
    w_burst_ok = (r_burst_cnt < BURST_MAX);
    case (r_state)
      OWN_A: begin
        if (a_req && (w_burst_ok || !b_req)) begin
          w_gnt_a = 1'b1;
        end else if (b_req) begin
          w_gnt_b = 1'b1;
        end
      end
      OWN_B: begin
        if (b_req && (w_burst_ok || !a_req)) begin
          w_gnt_b = 1'b1;
        end else if (a_req) begin
          w_gnt_a = 1'b1;
        end
      end
      default: begin
        if (a_req && b_req) begin
          if (r_rr_last == SIDE_B) begin
            w_gnt_a = 1'b1;
          end else begin
            w_gnt_b = 1'b1;
          end
        end else if (a_req) begin
          w_gnt_a = 1'b1;
        end else if (b_req) begin
          w_gnt_b = 1'b1;
        end
      end
    endcase
`endif
  end

  assign w_any_gnt = w_gnt_a | w_gnt_b;
  assign w_we      = w_gnt_b ? b_we    : a_we;
  assign w_addr    = w_gnt_b ? b_addr  : a_addr;
  assign w_wdata   = w_gnt_b ? b_wdata : a_wdata;

  // Owner FSM with burst counter and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
      r_rr_last   <= SIDE_B;
      r_burst_cnt <= '0;
`endif
    end else begin
      if (w_gnt_a) begin
        r_state <= OWN_A;
      end else if (w_gnt_b) begin
        r_state <= OWN_B;
      end else begin
        r_state <= IDLE;
      end
`ifndef ARB_FIXED_PRIO_EN
      if (w_gnt_a) begin
        r_rr_last <= SIDE_A;
      end else if (w_gnt_b) begin
        r_rr_last <= SIDE_B;
      end
      if ((w_gnt_a && r_state == OWN_A) || (w_gnt_b && r_state == OWN_B)) begin
        if (w_burst_ok) begin
          r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
      end else if (w_any_gnt) begin
        r_burst_cnt <= CNT_W'(1);
      end
`endif
    end
  end

  // Registered RAM command; addresses and data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_din        <= '0;
      mem_addr_wr    <= '0;
      mem_addr_rd    <= '0;
      mem_wr_en      <= 1'b0;
      mem_rd_en      <= 1'b0;
      mem_blk_select <= 1'b0;
    end else begin
      mem_wr_en      <= w_any_gnt & w_we;
      mem_rd_en      <= w_any_gnt & ~w_we;
      mem_blk_select <= w_any_gnt;
      if (w_any_gnt && w_we) begin
        mem_addr_wr <= w_addr;
        mem_din     <= w_wdata;
      end
      if (w_any_gnt && !w_we) begin
        mem_addr_rd <= w_addr;
      end
    end
  end

  // Read-return tag pipeline: command cycle, then RAM output cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_pend_a <= 1'b0;
      r_rd_pend_b <= 1'b0;
      r_rvalid_a  <= 1'b0;
      r_rvalid_b  <= 1'b0;
    end else begin
      r_rd_pend_a <= w_gnt_a & ~a_we;
      r_rd_pend_b <= w_gnt_b & ~b_we;
      r_rvalid_a  <= r_rd_pend_a;
      r_rvalid_b  <= r_rd_pend_b;
    end
  end

  assign a_gnt    = w_gnt_a;
  assign b_gnt    = w_gnt_b;
  assign a_rvalid = r_rvalid_a;
  assign b_rvalid = r_rvalid_b;
  assign rdata    = mem_dout;

endmodule
